// File: rtl/switch_feedback_beeper_pkg.sv
// Shared definitions for the switch feedback beeper: FSM encoding, beep counts
// and default tick durations at the 0.1 ms divided clock.
package switch_feedback_beeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } beep_state_t;

  localparam logic [1:0] ON_BEEPS  = 2'd1;
  localparam logic [1:0] OFF_BEEPS = 2'd2;

  localparam int DEFAULT_BEEP_TICKS = 1000;
  localparam int DEFAULT_GAP_TICKS  = 1000;
  localparam int DEFAULT_CNT_W      = 12;

  // Turning on is acknowledged with one beep, turning off with two.
  function automatic logic [1:0] beeps_for(input logic is_rise);
    return is_rise ? ON_BEEPS : OFF_BEEPS;
  endfunction

endpackage

// File: rtl/switch_feedback_beeper_edge_sync.sv
// Two-flop synchronizer plus registered rise/fall detector for an asynchronous
// panel level; edges are suppressed until the first ARM_EDGES clocks have passed.
module switch_feedback_beeper_edge_sync #(
  parameter int ARM_EDGES = 3
) (
  input  logic Div_CLK,
  input  logic Rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  localparam int ARM_W = $clog2(ARM_EDGES + 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             prev_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic [ARM_W-1:0] arm_cnt_reg;
  logic             armed;

  // While unarmed prev still follows s2, so a level already present at reset
  // release is absorbed without being reported as an edge.
  assign armed = (arm_cnt_reg == ARM_W'(ARM_EDGES));

  always_ff @(posedge Div_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      prev_reg    <= 1'b0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
      arm_cnt_reg <= '0;
    end else begin
      s1_reg   <= async_in;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
      rise_reg <= armed & s2_reg & ~prev_reg;
      fall_reg <= armed & ~s2_reg & prev_reg;
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
      end
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/switch_feedback_beeper.sv
// Buzzer acknowledgement for the toggling panel switch: one beep on turn-on,
// two on turn-off, with a one-deep pending slot for edges arriving while busy.
module switch_feedback_beeper
  import switch_feedback_beeper_pkg::*;
#(
  parameter int BEEP_TICKS = DEFAULT_BEEP_TICKS,
  parameter int GAP_TICKS  = DEFAULT_GAP_TICKS,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic Div_CLK,
  input  logic Rst_n,
  input  logic Switch_in,
  output logic Buzzer,
  output logic Busy,
  output logic Dropped
);

  localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);

  logic rise;
  logic fall;
  logic edge_evt;
  logic [1:0] edge_beeps;

  beep_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       rem_reg, rem_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [1:0]       pend_beeps_reg, pend_beeps_next;
  logic             buzzer_reg, busy_reg, dropped_reg;
  logic             dropped_next;
  logic             consumed;

  switch_feedback_beeper_edge_sync #(
    .ARM_EDGES(3)
  ) u_edge_sync (
    .Div_CLK (Div_CLK),
    .Rst_n   (Rst_n),
    .async_in(Switch_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign edge_evt   = rise | fall;
  assign edge_beeps = beeps_for(rise);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    rem_next        = rem_reg;
    pend_valid_next = pend_valid_reg;
    pend_beeps_next = pend_beeps_reg;
    dropped_next    = 1'b0;
    consumed        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          rem_next   = pend_beeps_reg;
          cnt_next   = BEEP_LOAD;
          state_next = BEEP;
          consumed   = 1'b1;
        end else if (edge_evt) begin
          rem_next   = edge_beeps;
          cnt_next   = BEEP_LOAD;
          state_next = BEEP;
        end
      end
      BEEP: begin
        if (cnt_reg == '0) begin
          rem_next   = rem_reg - 2'd1;
          cnt_next   = GAP_LOAD;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (rem_reg != 2'd0) begin
          cnt_next   = BEEP_LOAD;
          state_next = BEEP;
        end else if (pend_valid_reg) begin
          rem_next   = pend_beeps_reg;
          cnt_next   = BEEP_LOAD;
          state_next = BEEP;
          consumed   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        rem_next   = 2'd0;
      end
    endcase

    // An edge that is not started immediately becomes the pending request;
    // it only counts as a drop if it displaces one nobody has consumed.
    if (edge_evt && (state_reg != IDLE || pend_valid_reg)) begin
      pend_valid_next = 1'b1;
      pend_beeps_next = edge_beeps;
      dropped_next    = pend_valid_reg & ~consumed;
    end else if (consumed) begin
      pend_valid_next = 1'b0;
    end
  end

  always_ff @(posedge Div_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rem_reg        <= 2'd0;
      pend_valid_reg <= 1'b0;
      pend_beeps_reg <= 2'd0;
      buzzer_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      dropped_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rem_reg        <= rem_next;
      pend_valid_reg <= pend_valid_next;
      pend_beeps_reg <= pend_beeps_next;
      buzzer_reg     <= (state_next == BEEP);
      busy_reg       <= (state_next != IDLE);
      dropped_reg    <= dropped_next;
    end
  end

  assign Buzzer  = buzzer_reg;
  assign Busy    = busy_reg;
  assign Dropped = dropped_reg;

endmodule

// File: tb/tb_switch_feedback_beeper.sv
// Directed bench for switch_feedback_beeper with BEEP_TICKS=4, GAP_TICKS=3.
// Bit k of each mask is the expected output value just after Div_CLK edge k.
module tb_switch_feedback_beeper;

  logic Div_CLK = 1'b0;
  logic Rst_n;
  logic Switch_in;
  logic Buzzer;
  logic Busy;
  logic Dropped;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  switch_feedback_beeper #(
    .BEEP_TICKS(4),
    .GAP_TICKS (3),
    .CNT_W     (12)
  ) dut (
    .Div_CLK  (Div_CLK),
    .Rst_n    (Rst_n),
    .Switch_in(Switch_in),
    .Buzzer   (Buzzer),
    .Busy     (Busy),
    .Dropped  (Dropped)
  );

  always #5 Div_CLK = ~Div_CLK;

  task automatic tick();
    @(posedge Div_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // tog bit j flips Switch_in so that the new level is first sampled at edge j.
  task automatic run(input string tag, input int n, input logic [63:0] buz,
                     input logic [63:0] busy, input logic [63:0] drop,
                     input logic [63:0] tog);
    int fails_before;
    fails_before = fail_cnt;
    if (tog[0]) Switch_in = ~Switch_in;
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("%s buzzer@%0d", tag, k), Buzzer, buz[k]);
      chk($sformatf("%s busy@%0d", tag, k), Busy, busy[k]);
      chk($sformatf("%s dropped@%0d", tag, k), Dropped, drop[k]);
      if (tog[k+1]) Switch_in = ~Switch_in;
    end
    $display("%s: %0d cycles checked, %0d wrong", tag, n, fail_cnt - fails_before);
  endtask

  initial begin
    Rst_n     = 1'b0;
    Switch_in = 1'b1;
    #2;
    chk("reset buzzer", Buzzer, 1'b0);
    chk("reset busy", Busy, 1'b0);
    chk("reset dropped", Dropped, 1'b0);
    $display("reset: outputs checked in reset");
    tick();
    tick();
    Rst_n = 1'b1;

    // Level already high at release must not beep.
    run("high_at_release", 20, 64'h0, 64'h0, 64'h0, 64'h0);

    // 1->0: H4 L3 H4 L3, Busy 14 cycles.
    run("fall", 19, 64'h3C78, 64'h1FFF8, 64'h0, 64'h1);

    // 0->1: high on edges 3-6, Busy on 3-9.
    run("rise", 12, 64'h78, 64'h3F8, 64'h0, 64'h1);

    // Fresh reset with the switch low, then let the edge detector arm.
    Rst_n     = 1'b0;
    Switch_in = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    repeat (4) tick();
    $display("reset: re-armed with switch low");

    // Rise, then fall during the beep: 1-beep then 2-beep back to back, Busy 21.
    run("rise_then_fall", 26, 64'h1E3C78, 64'hFFFFF8, 64'h0, 64'h21);

    // Rise starts, fall pends, rise overwrites (drop); only one beep follows.
    run("three_toggles", 21, 64'h3C78, 64'h1FFF8, 64'h80, 64'h15);

    // Fall, then reset during the second beep.
    run("fall_before_reset", 12, 64'hC78, 64'hFF8, 64'h0, 64'h1);
    Rst_n = 1'b0;
    #1;
    chk("async reset buzzer", Buzzer, 1'b0);
    chk("async reset busy", Busy, 1'b0);
    chk("async reset dropped", Dropped, 1'b0);
    $display("mid_pattern_reset: outputs checked right after Rst_n fell");
    @(posedge Div_CLK);
    #1;
    Rst_n = 1'b1;

    run("after_reset_quiet", 20, 64'h0, 64'h0, 64'h0, 64'h0);
    run("rise_after_reset", 12, 64'h78, 64'h3F8, 64'h0, 64'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/switch_feedback_beeper.md
Name: switch_feedback_beeper

Overview:
Output-side counterpart of the push-button switch detector. It consumes the debounced toggling switch level and drives the panel buzzer with an audible acknowledgement: one beep when the switch turns on, two beeps when it turns off. It sits between the switch-detection block and the buzzer pin, clocked by the 0.1 ms divided clock.

Parameters:
BEEP_TICKS, 1000, Div_CLK cycles the buzzer is high per beep (1000 = 100 ms); legal range 1..2^CNT_W.
GAP_TICKS, 1000, Div_CLK cycles of silence between beeps and after the last beep; legal range 1..2^CNT_W.
CNT_W, 12, width of the shared duration counter.

Ports:
Div_CLK  input  1  divided system clock, 0.1 ms period, rising-edge active
Rst_n  input  1  asynchronous, active-low reset
Switch_in  input  1  debounced toggling switch level; asynchronous to Div_CLK
Buzzer  output  1  buzzer drive, active high, registered
Busy  output  1  high while a beep pattern, including its trailing gap, is in progress
Dropped  output  1  one-cycle pulse when a pending request is overwritten

Behaviour:
- Reset: Buzzer=0, Busy=0, Dropped=0, FSM=IDLE, counter=0, pending cleared, sync flops=0, edge detector unarmed.
- Reset asserted mid-pattern: all outputs go to 0 immediately. There is no completion or replay after release.
- Input path: 2-flop synchronizer (s1, s2) feeds a prev register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- Arming: for the first 3 Div_CLK edges after Rst_n deasserts, prev tracks s2 and no edges are reported. A level that is already high at reset release produces no beep.
- Beep count: rise requests 1 beep; fall requests 2 beeps.
- Latency: if Switch_in is first sampled high at edge 0, the edge is detected at edge 2. The FSM enters BEEP and Buzzer is high from edge 3 when IDLE.
- FSM states:
  - IDLE: Buzzer=0, Busy=0. On an edge, or a pending request, load the remaining-beep count, set counter=BEEP_TICKS-1, go to BEEP.
  - BEEP: Buzzer=1, Busy=1. Counter decrements each cycle. At 0, decrement remaining beeps, set counter=GAP_TICKS-1, go to GAP.
  - GAP: Buzzer=0, Busy=1. Counter decrements each cycle. At 0:
    - if remaining beeps ≠ 0, reload BEEP_TICKS-1 and go to BEEP;
    - else if pending is set, load it, clear it, and go to BEEP directly;
    - else go to IDLE.
- Timing consequences:
  - Each beep is exactly BEEP_TICKS cycles high; each gap, including the trailing gap, is exactly GAP_TICKS cycles low.
  - Busy spans n·(BEEP_TICKS+GAP_TICKS) cycles for an n-beep pattern.
- Pending request (one deep): an edge detected while Busy=1 is stored as pending, holding its direction.
  - If pending is already set, the new edge overwrites it and Dropped pulses for that cycle.
  - An edge in the same cycle that GAP consumes pending is stored as the new pending; no drop.
- An edge in the cycle the FSM returns to IDLE is taken on the next cycle with no loss.
- Counter width: CNT_W unsigned, decrement-only, never wraps. Transitions occur at the value 0.

Decomposition:
- Shared package: FSM state encoding (IDLE, BEEP, GAP as a 2-bit enum), beep-count constants (ON_BEEPS=1, OFF_BEEPS=2), and the default tick constants.
- Sub-module edge_sync: synchronizer, prev register, arming counter, and the rise/fall outputs. It is reused for other asynchronous panel inputs.
- The FSM, counter and pending logic stay in the top module.

Test Plan:
(All scenarios use BEEP_TICKS=4, GAP_TICKS=3.)
- Reset with Switch_in=1, hold 20 cycles -> Buzzer stays 0, Busy stays 0.
- Switch_in 0→1 sampled at edge 0 -> Buzzer high on edges 3-6 and low on 7-9; Busy high on edges 3-9, then 0.
- Switch_in 1→0 -> Buzzer pattern H4 L3 H4 L3; Busy high for 14 cycles; exactly 2 Buzzer rising edges.
- Rise, then fall 2 cycles into the beep -> 1-beep pattern, then a 2-beep pattern starting the cycle after the trailing gap ends. Busy stays high continuously for 7+14=21 cycles; Dropped never pulses.
- Three toggles while Busy -> Dropped pulses exactly once, on the third toggle; only the latest direction's pattern follows.
- Rst_n low for 1 cycle during the second beep -> Buzzer and Busy go to 0 asynchronously. After release, no beeps occur until the next toggle; a toggle then gives normal 3-cycle latency once armed.
